// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: buffers one result per functional unit and drives up to three
// register-file write ports per cycle, rotating priority across sources.
module wb_write_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [TAG_W-1:0]          wr_reg1,
    output logic                      wren_reg1,
    output logic [DATA_W-1:0]         wr_d1,
    output logic [TAG_W-1:0]          wr_reg2,
    output logic                      wren_reg2,
    output logic [DATA_W-1:0]         wr_d2,
    output logic [TAG_W-1:0]          wr_reg3,
    output logic                      wren_reg3,
    output logic [DATA_W-1:0]         wr_d3,
    output logic [3:0]                pending_cnt
);

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned PTR_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] buf_v_q;
    logic [TAG_W-1:0]   buf_tag_q  [NUM_SRC];
    logic [DATA_W-1:0]  buf_data_q [NUM_SRC];
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0] grant;

    logic               port_en_d   [NUM_PORTS];
    logic [TAG_W-1:0]   port_tag_d  [NUM_PORTS];
    logic [DATA_W-1:0]  port_data_d [NUM_PORTS];
    logic               port_en_q   [NUM_PORTS];
    logic [TAG_W-1:0]   port_tag_q  [NUM_PORTS];
    logic [DATA_W-1:0]  port_data_q [NUM_PORTS];

    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   last_sel;
    logic               any_grant;
    logic               conflict;
    logic [1:0]         used;

    // Round-robin scan from rr_ptr; stops once all three write ports are claimed.
    always_comb begin
        grant     = '0;
        sel       = '0;
        last_sel  = '0;
        any_grant = 1'b0;
        conflict  = 1'b0;
        used      = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_en_d[p]   = 1'b0;
            port_tag_d[p]  = '0;
            port_data_d[p] = '0;
        end
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            sel = PTR_W'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (buf_v_q[sel] && (used != 2'(NUM_PORTS))) begin
                if (buf_tag_q[sel] == '0) begin
                    // x0 writes are dropped but still count as a grant
                    grant[sel] = 1'b1;
                    last_sel   = sel;
                    any_grant  = 1'b1;
                end else begin
                    conflict = 1'b0;
                    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                        if (port_en_d[p] && (port_tag_d[p] == buf_tag_q[sel])) begin
                            conflict = 1'b1;
                        end
                    end
                    if (!conflict) begin
                        grant[sel]        = 1'b1;
                        last_sel          = sel;
                        any_grant         = 1'b1;
                        port_en_d[used]   = 1'b1;
                        port_tag_d[used]  = buf_tag_q[sel];
                        port_data_d[used] = buf_data_q[sel];
                        used              = used + 2'd1;
                    end
                end
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = (last_sel == PTR_W'(NUM_SRC - 1)) ? '0 : last_sel + 1'b1;
        end
    end

    always_comb begin
        src_ready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = rst_n && !flush && (!buf_v_q[i] || grant[i]);
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pending_cnt = pending_cnt + 4'(buf_v_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v_q <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                buf_tag_q[i]  <= '0;
                buf_data_q[i] <= '0;
            end
        end else if (flush) begin
            buf_v_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    buf_v_q[i]    <= 1'b1;
                    buf_tag_q[i]  <= src_tag[i*TAG_W +: TAG_W];
                    buf_data_q[i] <= src_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    buf_v_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (!flush) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                port_en_q[p]   <= 1'b0;
                port_tag_q[p]  <= '0;
                port_data_q[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                port_en_q[p]   <= flush ? 1'b0 : port_en_d[p];
                port_tag_q[p]  <= flush ? '0 : port_tag_d[p];
                port_data_q[p] <= flush ? '0 : port_data_d[p];
            end
        end
    end

    assign wren_reg1 = port_en_q[0];
    assign wr_reg1   = port_tag_q[0];
    assign wr_d1     = port_data_q[0];
    assign wren_reg2 = port_en_q[1];
    assign wr_reg2   = port_tag_q[1];
    assign wr_d2     = port_data_q[1];
    assign wren_reg3 = port_en_q[2];
    assign wr_reg3   = port_tag_q[2];
    assign wr_d3     = port_data_q[2];

endmodule
